// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: op codes, amount-source selects, FSM states.
// Rotate ops count as legal only when SHIFT_ROTATE_EN is defined.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_SLL  = 3'b001,
        OP_SRL  = 3'b010,
        OP_SRA  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        AMT_OFFSET  = 2'b00,
        AMT_CONST   = 2'b01,
        AMT_REGB    = 2'b10,
        AMT_ILLEGAL = 2'b11
    } amt_sel_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_PASS, OP_SLL, OP_SRL, OP_SRA: ok = 1'b1;
`ifdef SHIFT_ROTATE_EN
            OP_ROL, OP_ROR:                  ok = 1'b1;
`endif
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/shift_amt_sel.sv
// Combinational shift-amount source select; amounts are truncated/zero-extended to SHAMT_W.
// amt_sel=11 yields amount 0 and raises illegal.
module shift_amt_sel
    import shift_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CONST_AMT = 16
) (
    input  logic [1:0]                 amt_sel,
    input  logic [15:0]                offset,
    input  logic [DATA_W-1:0]          reg_b,
    output logic [$clog2(DATA_W)-1:0]  amount,
    output logic                       illegal
);

    localparam int SHAMT_W = $clog2(DATA_W);

    // Only offset[10:6] and the low reg_b bits feed the amount.
    logic unused_bits;
    assign unused_bits = ^{offset, reg_b};

    always_comb begin
        amount  = '0;
        illegal = 1'b0;
        case (amt_sel)
            AMT_OFFSET: amount = SHAMT_W'(offset[10:6]);
            AMT_CONST:  amount = SHAMT_W'(CONST_AMT);
            AMT_REGB:   amount = reg_b[SHAMT_W-1:0];
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Bit-serial shifter: one bit per clock, done pulses amount+1 edges after the accepting edge.
// Starts are only taken in IDLE; rotate ops exist only with SHIFT_ROTATE_EN defined.
module shift_seq_unit
    import shift_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CONST_AMT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [1:0]        amt_sel,
    input  logic [15:0]       offset,
    input  logic [DATA_W-1:0] reg_b,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result
);

    localparam int SHAMT_W = $clog2(DATA_W);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                err_q, err_d;

    logic [SHAMT_W-1:0]  sel_amt;
    logic                sel_illegal;

    shift_amt_sel #(
        .DATA_W    (DATA_W),
        .CONST_AMT (CONST_AMT)
    ) u_amt_sel (
        .amt_sel (amt_sel),
        .offset  (offset),
        .reg_b   (reg_b),
        .amount  (sel_amt),
        .illegal (sel_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= OP_PASS;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!op_legal(op) || sel_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        result_d = data_in;
                        op_d     = op;
                        cnt_d    = (op == OP_PASS) ? '0 : sel_amt;
                        state_d  = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - SHAMT_W'(1);
                    case (op_q)
                        OP_SLL:  result_d = {result_q[DATA_W-2:0], 1'b0};
                        OP_SRL:  result_d = {1'b0, result_q[DATA_W-1:1]};
                        OP_SRA:  result_d = {result_q[DATA_W-1], result_q[DATA_W-1:1]};
`ifdef SHIFT_ROTATE_EN
                        OP_ROL:  result_d = {result_q[DATA_W-2:0], result_q[DATA_W-1]};
                        OP_ROR:  result_d = {result_q[0], result_q[DATA_W-1:1]};
`endif
                        default: result_d = result_q;
                    endcase
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed and randomized stimulus for shift_seq_unit against an arithmetic reference model.
module tb_shift_seq_unit;

`ifdef SHIFT_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [1:0]  amt_sel;
    logic [15:0] offset;
    logic [31:0] reg_b;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;

    int          passed;
    int          total;
    logic [31:0] exp_res;

    shift_seq_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .amt_sel (amt_sel),
        .offset  (offset),
        .reg_b   (reg_b),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input int amt, input logic [31:0] d);
        logic signed [31:0] sd;
        sd = d;
        case (o)
            3'd1:    return d << amt;
            3'd2:    return d >> amt;
            3'd3:    return sd >>> amt;
            3'd4:    return (amt == 0) ? d : ((d << amt) | (d >> (32 - amt)));
            3'd5:    return (amt == 0) ? d : ((d >> amt) | (d << (32 - amt)));
            default: return d;
        endcase
    endfunction

    // Called at #1 after a rising edge; leaves the bench at #1 after a rising edge with the unit idle.
    task automatic do_op(input logic [2:0] o, input logic [1:0] s, input logic [15:0] off,
                         input logic [31:0] rb, input logic [31:0] din, input bit noisy);
        bit legal;
        int amt;
        int n;
        legal = (s != 2'b11) && ((o <= 3'd3) || (ROT_EN && (o == 3'd4 || o == 3'd5)));
        case (s)
            2'b00:   amt = int'(off[10:6]);
            2'b01:   amt = 16;
            default: amt = int'(rb[4:0]);
        endcase
        if (o == 3'd0) amt = 0;
        start = 1'b1; op = o; amt_sel = s; offset = off; reg_b = rb; data_in = din;
        @(posedge clk); #1;
        start = 1'b0;
        if (!legal) begin
            check("err_pulse", err, 1);
            check("err_busy", busy, 0);
            check("err_result", result, exp_res);
            @(posedge clk); #1;
            check("err_one_cycle", err, 0);
            check("err_still_idle", busy, 0);
            return;
        end
        exp_res = model(o, amt, din);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            check("busy_run", busy, 1);
            check("no_err_run", err, 0);
            if (noisy) begin
                start   = 1'($urandom_range(0, 1));
                op      = 3'($urandom_range(0, 7));
                amt_sel = 2'($urandom_range(0, 3));
                data_in = $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, amt + 1);
        check("done_high", done, 1);
        check("busy_in_done", busy, 1);
        check("result", result, exp_res);
        if (noisy) begin
            start = 1'b1; op = 3'd1; amt_sel = 2'b00; data_in = ~din;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("no_err_after", err, 0);
        check("result_held", result, exp_res);
    endtask

    initial begin
        passed = 0; total = 0; exp_res = '0;
        reset = 1'b1; start = 1'b0; op = '0; amt_sel = '0; offset = '0; reg_b = '0; data_in = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // First start right after reset release, SLL by offset[10:6]=3.
        do_op(3'd1, 2'b00, 16'd3 << 6, 32'h0, 32'h0000_0001, 1'b0);
        check("sll_value", result, 32'h0000_0008);
        do_op(3'd3, 2'b01, 16'h0, 32'h0, 32'h8000_0000, 1'b1);
        check("sra_value", result, 32'hFFFF_8000);
        do_op(3'd2, 2'b10, 16'h0, 32'h0000_0024, 32'hF000_0000, 1'b0);
        check("srl_value", result, 32'h0F00_0000);
        do_op(3'd0, 2'b01, 16'hFFFF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0);
        do_op(3'd1, 2'b11, 16'h0, 32'h0, 32'h1234_5678, 1'b0);
        do_op(3'd7, 2'b00, 16'h0, 32'h0, 32'h1234_5678, 1'b0);
        do_op(3'd1, 2'b10, 16'h0, 32'h0000_0020, 32'hA5A5_A5A5, 1'b1);
        do_op(3'd5, 2'b00, 16'd4 << 6, 32'h0, 32'h0000_000F, 1'b0);
        if (ROT_EN) check("ror_value", result, 32'hF000_0000);
        do_op(3'd4, 2'b10, 16'h0, 32'h0000_0001, 32'h8000_0001, 1'b0);

        // Reset in the middle of a long shift.
        start = 1'b1; op = 3'd3; amt_sel = 2'b01; data_in = 32'h8765_4321;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_result", result, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_res = '0;
        for (int i = 0; i < 20; i++) begin
            check("no_done_after_rst", done, 0);
            @(posedge clk); #1;
        end
        do_op(3'd2, 2'b00, 16'd1 << 6, 32'h0, 32'h0000_0100, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 16'($urandom),
                  $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_seq_unit.md
SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width (power of 2, 8..64).
REQ-002 SHALL have parameter CONST_AMT, default 16, fixed shift amount for amt_sel=01; must be < DATA_W.
REQ-003 SHALL have derived localparam SHAMT_W = clog2(DATA_W), 5 at default.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  request; sampled only in IDLE.
REQ-008 op  in  3  000 PASS, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR; others illegal.
REQ-009 amt_sel  in  2  00 offset[10:6], 01 CONST_AMT, 10 reg_b low bits, 11 illegal.
REQ-010 offset  in  16  instruction immediate field.
REQ-011 reg_b  in  DATA_W  register-B operand (variable shift).
REQ-012 data_in  in  DATA_W  value to shift.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 done  out  1  one-cycle pulse, result valid.
REQ-015 err  out  1  one-cycle pulse on rejected start.
REQ-016 result  out  DATA_W  shifted value, held until next accepted start.

Function
REQ-017 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-018 IDLE with start=1 and legal op/amt_sel SHALL latch data_in into result, op, and amount (selected source truncated/zero-extended to SHAMT_W) into counter; next state SHIFT.
REQ-019 IDLE with start=1 and illegal op or amt_sel=11 SHALL pulse err the next cycle, leave result unchanged, stay IDLE; no latch is inferred for any select value.
REQ-020 SHIFT with counter != 0 SHALL shift result by one bit per edge per op and decrement counter.
REQ-021 SHIFT with counter == 0 SHALL go to DONE without modifying result.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 Latency: done visible amount+1 edges after the start-sampling edge; amount 0 gives done after 1 edge with result = data_in.
REQ-024 PASS SHALL force amount 0 regardless of amt_sel.
REQ-025 SLL/SRL SHALL fill with 0; SRA SHALL replicate result[DATA_W-1]; ROL/ROR SHALL feed out-shifted bit back in.
REQ-026 start while busy SHALL be ignored (no err, no effect on current operation).
REQ-027 start in the DONE cycle SHALL be ignored; earliest acceptance is the following IDLE cycle.

Reset
REQ-028 reset SHALL immediately force IDLE, result=0, counter=0, busy=0, done=0, err=0, including mid-SHIFT.
REQ-029 After reset release, first start SHALL be accepted on the first rising edge with start=1.

Configuration
REQ-030 Macro SHIFT_ROTATE_EN defined: ROL/ROR legal as REQ-025.
REQ-031 SHIFT_ROTATE_EN undefined: op 100/101 illegal, handled per REQ-019; no rotate logic synthesised.

Structure
REQ-032 Package shift_pkg SHALL hold op encodings, amt_sel encodings, FSM state enum.
REQ-033 Amount selection SHALL be a combinational sub-module shift_amt_sel (amt_sel, offset, reg_b -> amount, illegal flag).

Verification
REQ-034 SLL, amt_sel=00, offset[10:6]=3, data_in=0x0000_0001 -> done 4 edges after start, result=0x0000_0008.
REQ-035 SRA, amt_sel=01 (16), data_in=0x8000_0000 -> done after 17 edges, result=0xFFFF_8000; busy high throughout.
REQ-036 SRL, amt_sel=10, reg_b=0x0000_0024 (low 5 bits=4), data_in=0xF000_0000 -> result=0x0F00_0000.
REQ-037 amt_sel=11 or op=111 with start -> err pulse 1 cycle, busy stays 0, result unchanged; start during SHIFT ignored.
REQ-038 Reset asserted mid-SHIFT -> result=0, IDLE, no done; ROR amount 4 of 0x0000_000F -> 0xF000_0000 with macro, err without.
